ddr_rd_arbiter: RTL and testbench

DDR_RD_ARBITER -- requirements
Module: ddr_rd_arbiter

---
 rtl/ddr_arb_pkg.sv | 16 +
 rtl/ddr_arb_tag_fifo.sv | 68 ++++++
 rtl/ddr_rd_arbiter.sv | 113 +++++++++++
 tb/tb_ddr_rd_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared defaults and helpers for the DDR read arbiter slice.
package ddr_arb_pkg;

  localparam int DEF_NUM_REQ         = 4;
  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_MAX_OUTSTANDING = 8;
  localparam int DATA_W              = 8;

  typedef logic [DATA_W-1:0] ddr_byte_t;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_arb_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each in-flight read.
module ddr_arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];

  // Pointer advance with explicit wrap, and occupancy tracking.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage write port.
  // NOTE: storage is not reset; entries are only read after being written, and count gates validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin read arbiter in front of a single in-order DDR read port,
// with credit limiting and response routing by tag.
module ddr_rd_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_REQ         = DEF_NUM_REQ,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int ID_W            = id_width(NUM_REQ)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]                req_addr,
  output logic [NUM_REQ-1:0]                       req_ready,
  output logic [NUM_REQ-1:0]                       rsp_valid,
  output logic [DATA_W-1:0]                        rsp_data,
  output logic                                     mem_req_valid,
  output logic [ADDR_W-1:0]                        mem_req_addr,
  input  logic                                     mem_rsp_valid,
  input  logic [DATA_W-1:0]                        mem_rsp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
  output logic                                     err_orphan
);

  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic               mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0]  mem_req_addr_q, mem_req_addr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  ddr_byte_t          rsp_data_q, rsp_data_d;
  logic               err_orphan_q, err_orphan_d;

  logic [ID_W-1:0]    grant_idx;
  logic               grant_found;
  logic               handshake;
  logic               pop;
  logic [ID_W-1:0]    fifo_dout;
  logic               fifo_full, fifo_empty;

  // Find the first valid requester after the last granted one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  // Offer the grant only with a free credit; a same-cycle response does not count.
  always_comb begin
    req_ready = '0;
    if (!rst && !fifo_full && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign handshake = |(req_valid & req_ready);
  assign pop       = mem_rsp_valid & ~fifo_empty;

  // Next-state: issue the granted read, route the response, flag orphans.
  always_comb begin
    last_grant_d    = handshake ? grant_idx : last_grant_q;
    mem_req_valid_d = handshake;
    mem_req_addr_d  = handshake ? req_addr[int'(grant_idx)*ADDR_W +: ADDR_W] : mem_req_addr_q;
    rsp_valid_d     = '0;
    if (pop) rsp_valid_d[fifo_dout] = 1'b1;
    rsp_data_d      = pop ? mem_rsp_data : rsp_data_q;
    err_orphan_d    = err_orphan_q | (mem_rsp_valid & fifo_empty);
  end

  // Output and arbitration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q    <= ID_W'(NUM_REQ - 1);
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
      err_orphan_q    <= 1'b0;
    end else begin
      last_grant_q    <= last_grant_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      err_orphan_q    <= err_orphan_d;
    end
  end

  ddr_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W),
    .CNT_W ($clog2(MAX_OUTSTANDING + 1))
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (handshake),
    .pop   (pop),
    .din   (grant_idx),
    .dout  (fifo_dout),
    .count (outstanding),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign err_orphan    = err_orphan_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Self-checking bench for ddr_rd_arbiter: transaction-level model, DDR model
// with 4-cycle request-to-response latency, directed and random traffic.
module tb_ddr_rd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int MAX_OUT = 8;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);

  logic                      clk, rst;
  logic [NUM_REQ-1:0]        req_valid, req_ready, rsp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [7:0]                rsp_data, mem_rsp_data;
  logic                      mem_req_valid, mem_rsp_valid, err_orphan;
  logic [ADDR_W-1:0]         mem_req_addr;
  logic [CNT_W-1:0]          outstanding;

  ddr_rd_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Memory content: a fixed function of the address (0x10 reads 0xA5).
  function automatic logic [7:0] ddr_byte(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hB5;
  endfunction

  // Environment controls, written only by the stimulus process.
  bit ddr_stall  = 1'b0;
  bit inject_rsp = 1'b0;
  int rel_req    = 0;

  // DDR model: response 4 cycles after the request, in order; can be stalled.
  int                ddr_due[$];
  logic [ADDR_W-1:0] ddr_addr[$];
  int                mrsp_cyc[$];
  int                rel_done;
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    rel_done      = 0;
    forever begin
      @(posedge clk);
      #2;
      mem_rsp_valid = 1'b0;
      if (inject_rsp) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 8'($urandom);
      end else if (ddr_due.size() > 0 && ddr_due[0] <= cycle && (!ddr_stall || rel_done < rel_req)) begin
        if (ddr_stall) rel_done++;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = ddr_byte(ddr_addr[0]);
        void'(ddr_due.pop_front());
        void'(ddr_addr.pop_front());
      end
      if (mem_rsp_valid) mrsp_cyc.push_back(cycle);
      @(negedge clk);
      if (mem_req_valid) begin
        ddr_due.push_back(cycle + 4);
        ddr_addr.push_back(mem_req_addr);
      end
    end
  end

  // Reference model state and observation logs.
  int                m_last;
  int                m_tags[$];
  logic              m_err;
  logic [NUM_REQ-1:0] m_rsp_valid;
  logic [7:0]        m_rsp_data;
  logic              m_mreq_v;
  logic [ADDR_W-1:0] m_mreq_a;
  int gnt_cyc[$], gnt_id[$], mreq_cyc[$], rsp_cyc[$], rsp_id[$];
  logic [7:0] rsp_dat[$];
  bit pp_prev = 1'b0;
  int pp_seen = 0;
  int g, c, popped;
  logic [NUM_REQ-1:0] exp_ready;

  task automatic model_reset();
    m_last      = NUM_REQ - 1;
    m_tags.delete();
    m_err       = 1'b0;
    m_rsp_valid = '0;
    m_rsp_data  = '0;
    m_mreq_v    = 1'b0;
    m_mreq_a    = '0;
  endtask

  // Compare process: every cycle, at the falling edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      g = -1;
      if (!rst && m_tags.size() < MAX_OUT) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          c = (m_last + k) % NUM_REQ;
          if (g < 0 && req_valid[c]) g = c;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("mem_req_valid", 64'(mem_req_valid), 64'(m_mreq_v));
      check("mem_req_addr", 64'(mem_req_addr), 64'(m_mreq_a));
      check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
      check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
      check("outstanding", 64'(outstanding), 64'(m_tags.size()));
      check("err_orphan", 64'(err_orphan), 64'(m_err));
      if (pp_prev && !rst) check("push_pop_hold", 64'(outstanding), 64'd5);
      pp_prev = !rst && (|(req_valid & req_ready)) && mem_rsp_valid && (outstanding == CNT_W'(5));
      if (pp_prev) pp_seen++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin gnt_cyc.push_back(cycle); gnt_id.push_back(i); end
        if (rsp_valid[i]) begin rsp_cyc.push_back(cycle); rsp_id.push_back(i); rsp_dat.push_back(rsp_data); end
      end
      if (mem_req_valid) mreq_cyc.push_back(cycle);
      if (!rst) begin
        if (mem_rsp_valid) begin
          if (m_tags.size() == 0) begin
            m_err       = 1'b1;
            m_rsp_valid = '0;
          end else begin
            popped      = m_tags.pop_front();
            m_rsp_valid = '0;
            m_rsp_valid[popped] = 1'b1;
            m_rsp_data  = mem_rsp_data;
          end
        end else begin
          m_rsp_valid = '0;
        end
        if (g >= 0) begin
          m_tags.push_back(g);
          m_last   = g;
          m_mreq_v = 1'b1;
          m_mreq_a = req_addr[g*ADDR_W +: ADDR_W];
        end else begin
          m_mreq_v = 1'b0;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_addrs();
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_tags.size() != 0 || ddr_due.size() != 0) && n < 300) begin
      next_cycle();
      n++;
    end
    check("drain_done", 64'(m_tags.size() + ddr_due.size()), 64'd0);
    next_cycle();
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int bg, br, bm, t0, x0;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    // Requests during reset must never be granted.
    repeat (3) begin
      next_cycle();
      req_valid = NUM_REQ'($urandom);
      rand_addrs();
    end
    next_cycle();
    rst = 1'b0;
    req_valid = '0;
    next_cycle();

    // All four requesters valid for 8 cycles: grants 0,1,2,3,0,1,2,3.
    bg = gnt_id.size();
    br = rsp_id.size();
    req_valid = '1;
    rand_addrs();
    repeat (8) begin next_cycle(); rand_addrs(); end
    req_valid = '0;
    drain();
    check("rr_grant_count", 64'(gnt_id.size() - bg), 64'd8);
    check("rr_rsp_count", 64'(rsp_id.size() - br), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check("rr_grant_order", 64'(gnt_id[bg+i]), 64'(i % 4));
      check("rr_rsp_order", 64'(rsp_id[br+i]), 64'(i % 4));
    end

    // Single read of 0x10 by requester 0: memory at +1, response 0xA5 at +6.
    bg = gnt_cyc.size();
    bm = mreq_cyc.size();
    br = rsp_cyc.size();
    req_valid = 4'b0001;
    req_addr[ADDR_W-1:0] = 32'h10;
    t0 = cycle;
    next_cycle();
    req_valid = '0;
    repeat (8) next_cycle();
    check("single_grant_cycle", 64'(gnt_cyc[bg] - t0), 64'd0);
    check("single_memreq_latency", 64'(mreq_cyc[bm] - t0), 64'd1);
    check("single_rsp_latency", 64'(rsp_cyc[br] - t0), 64'd6);
    check("single_rsp_id", 64'(rsp_id[br]), 64'd0);
    check("single_rsp_data", 64'(rsp_dat[br]), 64'hA5);

    // Credit limit: responses held, exactly 8 grants, then one release.
    ddr_stall = 1'b1;
    bg = gnt_cyc.size();
    req_valid = '1;
    rand_addrs();
    repeat (11) next_cycle();
    check("credit_grants", 64'(gnt_cyc.size() - bg), 64'd8);
    check("credit_outstanding", 64'(outstanding), 64'd8);
    check("credit_ready_zero", 64'(req_ready), 64'd0);
    rel_req++;
    x0 = cycle;
    repeat (3) next_cycle();
    check("credit_regrant_count", 64'(gnt_cyc.size() - bg), 64'd9);
    check("credit_regrant_cycle", 64'(gnt_cyc[bg+8] - x0), 64'd1);
    req_valid = '0;
    ddr_stall = 1'b0;
    drain();

    // 20 back-to-back reads: FIFO wraps, steady state pushes and pops at 5.
    bg = gnt_cyc.size();
    br = rsp_cyc.size();
    req_valid = '1;
    repeat (20) begin rand_addrs(); next_cycle(); end
    req_valid = '0;
    drain();
    check("b2b_grants", 64'(gnt_cyc.size() - bg), 64'd20);
    check("b2b_rsps", 64'(rsp_cyc.size() - br), 64'd20);
    check("b2b_push_pop_seen", 64'(pp_seen > 0), 64'd1);

    // Random traffic with random DDR stalls and single-response releases.
    repeat (300) begin
      next_cycle();
      req_valid = NUM_REQ'($urandom);
      rand_addrs();
      if ($urandom_range(0, 19) == 0) ddr_stall = !ddr_stall;
      if (ddr_stall && $urandom_range(0, 2) == 0) rel_req++;
    end
    req_valid = '0;
    ddr_stall = 1'b0;
    drain();

    // Orphan response with nothing in flight.
    br = rsp_cyc.size();
    inject_rsp = 1'b1;
    next_cycle();
    inject_rsp = 1'b0;
    next_cycle();
    check("orphan_set", 64'(err_orphan), 64'd1);
    check("orphan_no_rsp", 64'(rsp_cyc.size() - br), 64'd0);
    check("orphan_outstanding", 64'(outstanding), 64'd0);
    repeat (5) next_cycle();
    check("orphan_sticky", 64'(err_orphan), 64'd1);

    // Reset with three reads in flight; their late responses become orphans.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    req_valid = 4'b0111;
    rand_addrs();
    repeat (3) next_cycle();
    req_valid = '0;
    check("inflight_before_reset", 64'(outstanding), 64'd3);
    next_cycle();
    rst = 1'b1;
    #1;
    check("reset_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("reset_mem_req_addr", 64'(mem_req_addr), 64'd0);
    check("reset_outstanding", 64'(outstanding), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_err_orphan", 64'(err_orphan), 64'd0);
    br = rsp_cyc.size();
    bm = mrsp_cyc.size();
    next_cycle();
    rst = 1'b0;
    repeat (10) next_cycle();
    check("late_rsp_delivered", 64'(mrsp_cyc.size() - bm), 64'd3);
    check("late_orphan_err", 64'(err_orphan), 64'd1);
    check("late_no_rsp", 64'(rsp_cyc.size() - br), 64'd0);
    check("late_outstanding", 64'(outstanding), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
